// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined CPU.
// Accepts one load or store request at a time, stalls the pipeline through
// MemBusy for the access latency, then performs an RV32 byte/half/word access
// against a byte-enabled word array and pulses MemReady for one cycle.

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,  // word-address bits; depth = 2**ADDR_WIDTH words
  parameter int LATENCY    = 2    // wait cycles before the access, 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        MemBusy,
  output logic        MemReady,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int AW = ADDR_WIDTH + 2;  // byte-address bits actually decoded

  // Request context, captured when the request is accepted.
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          store_q, store_d;

  // Registered response, only non-zero during DONE.
  logic          ready_q, ready_d;
  logic          misalign_q, misalign_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]           mem_word;

  logic        fn_valid, fn_half, fn_word, acc_misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        mem_we;

  // Address bits above the array wrap and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW];

  assign mem_idx  = addr_q[AW-1:2];
  assign mem_word = mem[mem_idx];

  // Decode the latched access: legality, alignment and store byte lanes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
    fn_valid = 1'b0;
    st_be    = 4'b0000;
    st_data  = wdata_q;
    fn_half  = (funct3_q[1:0] == 2'b01);
    fn_word  = (funct3_q == 3'b010);
    case (funct3_q)
      3'b000, 3'b100: begin
        fn_valid = 1'b1;
        st_be    = 4'b0001 << addr_q[1:0];
        st_data  = {4{wdata_q[7:0]}};
      end
      3'b001, 3'b101: begin
        fn_valid = 1'b1;
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        fn_valid = 1'b1;
        st_be    = 4'b1111;
      end
      default: ;
    endcase
    acc_misaligned = (fn_half && addr_q[0]) || (fn_word && (addr_q[1:0] != 2'b00));
  end

  // Extract and extend the load result from the addressed word.
  always_comb begin
    ld_byte = 8'(mem_word >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      3'b010:  ld_data = mem_word;
      default: ld_data = 32'd0;
    endcase
  end

  // Next-state logic for the IDLE -> WAIT -> DONE access sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    ready_d    = 1'b0;
    misalign_d = 1'b0;
    rdata_d    = 32'd0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          state_d  = WAIT;
          cnt_d    = 4'(LATENCY - 1);
          addr_d   = addr[AW-1:0];
          wdata_d  = wdata;
          funct3_d = funct3;
          store_d  = MemWrite;  // a simultaneous load is dropped
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = DONE;
          ready_d    = 1'b1;
          misalign_d = acc_misaligned;
          if (!store_q && !acc_misaligned) rdata_d = ld_data;
          mem_we     = store_q && fn_valid && !acc_misaligned;
        end
      end
      DONE:    state_d = IDLE;  // request inputs ignored here
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      store_q    <= 1'b0;
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      store_q    <= store_d;
      ready_q    <= ready_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
    end
  end

  // Byte-enabled array write on the WAIT -> DONE edge.
  // NOTE: the array has no reset; a reset during WAIT forces IDLE asynchronously, so mem_we is already low at the next edge and the store is discarded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[mem_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign MemBusy  = ((state_q == IDLE) && (MemRead || MemWrite)) || (state_q == WAIT);
  assign MemReady = ready_q;
  assign misalign = misalign_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance carries most of the
// traffic, a LATENCY=1 instance covers the short-latency and wrap case.
// Inputs are driven and outputs sampled around the falling edge.

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sel;           // 0: LATENCY=2 instance, 1: LATENCY=1 instance
  logic        rd_req, wr_req;
  logic [31:0] addr, wdata;
  logic [2:0]  funct3;

  logic        busy0, ready0, mis0, busy1, ready1, mis1;
  logic [31:0] rdata0, rdata1;
  logic        busy_m, ready_m, mis_m;
  logic [31:0] rdata_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .MemRead(rd_req & ~sel), .MemWrite(wr_req & ~sel),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .MemBusy(busy0), .MemReady(ready0), .rdata(rdata0), .misalign(mis0)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset_n(reset_n),
    .MemRead(rd_req & sel), .MemWrite(wr_req & sel),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .MemBusy(busy1), .MemReady(ready1), .rdata(rdata1), .misalign(mis1)
  );

  assign busy_m  = sel ? busy1  : busy0;
  assign ready_m = sel ? ready1 : ready0;
  assign mis_m   = sel ? mis1   : mis0;
  assign rdata_m = sel ? rdata1 : rdata0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access; called just after a falling edge with the DUT idle.
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_busy, input logic [31:0] exp_rd, input logic exp_mis);
    int busy_n = 0;
    bit seen   = 0;
    addr = a; wdata = wd; funct3 = f3; wr_req = wr; rd_req = ~wr;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (ready_m) begin
        seen = 1;
        check({tag, " rdata"},    rdata_m, exp_rd);
        check({tag, " misalign"}, 32'(mis_m), 32'(exp_mis));
        check({tag, " busy in DONE"}, 32'(busy_m), 32'd0);
        check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
      end else begin
        if (busy_m) busy_n++;
        @(negedge clk);
      end
    end
    if (!seen) check({tag, " ready timeout"}, 32'd0, 32'd1);
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk); #1;
    check({tag, " ready one cycle"}, 32'(ready_m), 32'd0);
    check({tag, " rdata idle"}, rdata_m, 32'd0);
  endtask

  logic [11:0] ready_pat, busy_pat;

  initial begin
    sel = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    addr = '0; wdata = '0; funct3 = 3'b010;
    reset_n = 1'b0;
    #1;
    check("reset ready",    32'(ready0), 32'd0);
    check("reset misalign", 32'(mis0),   32'd0);
    check("reset rdata",    rdata0,      32'd0);
    check("reset busy",     32'(busy0),  32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Word store and load, plus wrap and half loads of the same word.
    access("SW 10",   1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 3, 32'h0,        1'b0);
    access("LW 10",   1'b0, 3'b010, 32'h10,   32'h0,        3, 32'hDEADBEEF, 1'b0);
    access("LW 1010", 1'b0, 3'b010, 32'h1010, 32'h0,        3, 32'hDEADBEEF, 1'b0);
    access("LHU 12",  1'b0, 3'b101, 32'h12,   32'h0,        3, 32'h0000DEAD, 1'b0);
    access("LB 13",   1'b0, 3'b000, 32'h13,   32'h0,        3, 32'hFFFFFFDE, 1'b0);

    // Byte store into a known word, signed and unsigned byte loads.
    access("SW 20",   1'b1, 3'b010, 32'h20, 32'h01020304, 3, 32'h0,        1'b0);
    access("SB 21",   1'b1, 3'b000, 32'h21, 32'h00000080, 3, 32'h0,        1'b0);
    access("LB 21",   1'b0, 3'b000, 32'h21, 32'h0,        3, 32'hFFFFFF80, 1'b0);
    access("LBU 21",  1'b0, 3'b100, 32'h21, 32'h0,        3, 32'h00000080, 1'b0);
    access("LW 20",   1'b0, 3'b010, 32'h20, 32'h0,        3, 32'h01028004, 1'b0);

    // Halfword store, halfword loads, misaligned and illegal accesses.
    access("SW 30",   1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 3, 32'h0,        1'b0);
    access("SH 32",   1'b1, 3'b001, 32'h32, 32'h00001234, 3, 32'h0,        1'b0);
    access("LH 32",   1'b0, 3'b001, 32'h32, 32'h0,        3, 32'h00001234, 1'b0);
    access("LH 30",   1'b0, 3'b001, 32'h30, 32'h0,        3, 32'hFFFFF00D, 1'b0);
    access("LHU 30",  1'b0, 3'b101, 32'h30, 32'h0,        3, 32'h0000F00D, 1'b0);
    access("LH 33",   1'b0, 3'b001, 32'h33, 32'h0,        3, 32'h0,        1'b1);
    access("SH 33",   1'b1, 3'b001, 32'h33, 32'h0000BEEF, 3, 32'h0,        1'b1);
    access("SW 31",   1'b1, 3'b010, 32'h31, 32'h77777777, 3, 32'h0,        1'b1);
    access("SW f3=6", 1'b1, 3'b110, 32'h30, 32'h66666666, 3, 32'h0,        1'b0);
    access("L f3=3",  1'b0, 3'b011, 32'h30, 32'h0,        3, 32'h0,        1'b0);
    access("LW 30",   1'b0, 3'b010, 32'h30, 32'h0,        3, 32'h1234F00D, 1'b0);

    // Reset during the second WAIT cycle discards the store.
    access("SW 40",   1'b1, 3'b010, 32'h40, 32'h11223344, 3, 32'h0, 1'b0);
    addr = 32'h40; wdata = 32'hA5A5A5A5; funct3 = 3'b010; wr_req = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("abort busy in WAIT", 32'(busy0), 32'd1);
    reset_n = 1'b0; wr_req = 1'b0;
    #1;
    check("abort busy",     32'(busy0),  32'd0);
    check("abort ready",    32'(ready0), 32'd0);
    check("abort rdata",    rdata0,      32'd0);
    check("abort misalign", 32'(mis0),   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    access("LW 40",   1'b0, 3'b010, 32'h40, 32'h0, 3, 32'h11223344, 1'b0);

    // Back-to-back loads with the request held continuously.
    addr = 32'h10; funct3 = 3'b010; rd_req = 1'b1;
    ready_pat = '0; busy_pat = '0;
    for (int c = 0; c < 12; c++) begin
      #1;
      ready_pat[c] = ready0;
      busy_pat[c]  = busy0;
      if (ready0) check("b2b rdata", rdata0, 32'hDEADBEEF);
      @(negedge clk);
    end
    rd_req = 1'b0;
    check("b2b ready pattern", 32'(ready_pat), 32'h888);
    check("b2b busy pattern",  32'(busy_pat),  32'h777);
    @(negedge clk);

    // LATENCY=1 instance: store at 0x0, load through the wrapped alias.
    sel = 1'b1;
    access("L1 SW 0",    1'b1, 3'b010, 32'h0,    32'h55AA33CC, 2, 32'h0,        1'b0);
    access("L1 LW 1000", 1'b0, 3'b010, 32'h1000, 32'h0,        2, 32'h55AA33CC, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
